// File: rtl/keycode_event_sequencer.sv
// keycode_event_sequencer
//   Turns USB keyboard reports (keycode slots written by the NIOS into the
//   keycode PIO) into an ordered stream of press/release events. Each report
//   strobe is diffed against the previous report one slot per cycle. The
//   resulting events go into a first-word-fall-through FIFO that a
//   valid/ready consumer drains.
//
//   Ports
//     clk           in   system clock, rising edge
//     reset         in   synchronous active-high reset
//     keycode_in    in   current report, slot i = keycode_in[8*i+7:8*i], 0x00 = empty
//     report_strobe in   1-cycle pulse: keycode_in holds a new report
//     evt_valid     out  FIFO head valid
//     evt_ready     in   consumer accepts the head
//     evt_code      out  head keycode
//     evt_press     out  head type: 1 = press, 0 = release
//     busy          out  scan in progress (FSM not IDLE)
//     overflow      out  sticky: an event was dropped on a full FIFO
//     dbg_state_o   out  raw FSM state for observation
//
//   Handshake: the head transfers on any rising edge where evt_valid and
//   evt_ready are both high. evt_code/evt_press are stable while evt_valid is
//   high and not popped. The producer side never waits for the consumer.
module keycode_event_sequencer #(
  parameter int SLOTS      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*SLOTS-1:0] keycode_in,
  input  logic               report_strobe,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_press,
  output logic               busy,
  output logic               overflow,
  output logic [1:0]         dbg_state_o
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int W  = 8 * SLOTS;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCAN_REL   = 2'd1,
    SCAN_PRESS = 2'd2,
    COMMIT     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  prev_q, cur_q, pend_q;
  logic          pend_v_q, pend_v_d;
  logic          overflow_q;

  logic [8:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  logic          idx_last;
  logic [7:0]    prev_k, cur_k;
  logic          rel_hit, press_hit;
  logic          load_cur, push, pop, push_ok, full;
  logic [8:0]    push_data;

  assign idx_last = (idx_q == IW'(SLOTS - 1));

  // Slot comparison for the slot currently being scanned. A key counts only
  // at its first occurrence within its own report, so duplicated keycodes
  // yield a single event.
  always_comb begin
    logic in_cur, in_prev, dup_prev, dup_cur;
    prev_k   = 8'h00;
    cur_k    = 8'h00;
    in_cur   = 1'b0;
    in_prev  = 1'b0;
    dup_prev = 1'b0;
    dup_cur  = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (idx_q == IW'(i)) begin
        prev_k = prev_q[8*i +: 8];
        cur_k  = cur_q[8*i +: 8];
      end
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (cur_q[8*i +: 8] == prev_k) in_cur = 1'b1;
      if (prev_q[8*i +: 8] == cur_k) in_prev = 1'b1;
      if (IW'(i) < idx_q) begin
        if (prev_q[8*i +: 8] == prev_k) dup_prev = 1'b1;
        if (cur_q[8*i +: 8] == cur_k)   dup_cur  = 1'b1;
      end
    end
    rel_hit   = (prev_k != 8'h00) && !in_cur  && !dup_prev;
    press_hit = (cur_k  != 8'h00) && !in_prev && !dup_cur;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (report_strobe || pend_v_q) begin
          state_d = SCAN_REL;
          idx_d   = '0;
        end
      end
      SCAN_REL: begin
        idx_d = idx_q + 1'b1;
        if (idx_last) begin
          idx_d   = '0;
          state_d = SCAN_PRESS;
        end
      end
      SCAN_PRESS: begin
        idx_d = idx_q + 1'b1;
        if (idx_last) begin
          idx_d   = '0;
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_cur  = 1'b0;
    push      = 1'b0;
    push_data = 9'h000;
    case (state_q)
      IDLE:       load_cur = report_strobe || pend_v_q;
      SCAN_REL: begin
        push      = rel_hit;
        push_data = {prev_k, 1'b0};
      end
      SCAN_PRESS: begin
        push      = press_hit;
        push_data = {cur_k, 1'b1};
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

  // A strobe seen in IDLE is consumed directly; otherwise it parks in pend,
  // replacing any report that has not been started yet.
  assign pend_v_d = !load_cur && (report_strobe || pend_v_q);

  // A push into a full FIFO still lands if the head pops on the same edge.
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = evt_valid && evt_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      cur_q      <= '0;
      prev_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 9'h000;
    end else begin
      if (report_strobe) pend_q <= keycode_in;
      pend_v_q <= pend_v_d;
      if (load_cur) cur_q <= report_strobe ? keycode_in : pend_q;
      if (state_q == COMMIT) prev_q <= cur_q;
      if (push_ok) begin
        fifo_q[wptr_q] <= push_data;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign evt_code  = fifo_q[rptr_q][8:1];
  assign evt_press = fifo_q[rptr_q][0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keycode_event_sequencer.sv
// Bench for keycode_event_sequencer: a hand-built vector table, fixed
// sequences for overflow, pending-report and mid-scan reset, and randomized
// reports checked against a set-based reference model.
module tb_keycode_event_sequencer;
  localparam int SLOTS = 4;
  localparam int DEPTH = 8;
  localparam int LAT   = 2 * SLOTS + 2;

  // clock / reset / DUT
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  keycode_in;
  logic         report_strobe;
  logic         evt_valid, evt_ready, evt_press, busy, overflow;
  logic [7:0]   evt_code;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  keycode_event_sequencer #(.SLOTS(SLOTS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .keycode_in(keycode_in),
    .report_strobe(report_strobe), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
    .busy(busy), .overflow(overflow), .dbg_state_o(dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  int          rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random
  logic [7:0]  model_prev[SLOTS];

  typedef struct {
    logic [31:0] rpt;
    int          n;
    logic [8:0]  ev0;
    logic [8:0]  ev1;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] s0, input logic [7:0] s1,
                                     input logic [7:0] s2, input logic [7:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [8:0] ev(input logic [7:0] code, input logic press);
    return {code, press};
  endfunction

  // scoreboard consumer: new ready is chosen first, then the head that will
  // pop on the coming rising edge is compared
  initial begin
    evt_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_mode == 2)      evt_ready = 1'($urandom_range(0, 1));
      else                    evt_ready = (rdy_mode == 1);
      if (!reset && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h, expected none", {evt_code, evt_press});
        end else begin
          check("event", {23'd0, evt_code, evt_press}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    report_strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < SLOTS; i++) model_prev[i] = 8'h00;
  endtask

  // lat = rising edges from the strobe edge until busy is low again
  task automatic send(input logic [31:0] r, output int lat);
    @(negedge clk);
    keycode_in    = r;
    report_strobe = 1'b1;
    @(negedge clk);
    report_strobe = 1'b0;
    lat = 1;
    while (busy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, 32'(t >= 300), 32'd0);
    repeat (2) @(negedge clk);
    check({name, "_empty"}, 32'(evt_valid), 32'd0);
  endtask

  // reference model: releases are keys of the old report missing from the
  // new one, presses are keys of the new report missing from the old one,
  // each listed once in order of first slot appearance
  function automatic bit has(input logic [7:0] q[$], input logic [7:0] k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_scan(input logic [31:0] r);
    logic [7:0] oldq[$];
    logic [7:0] newq[$];
    logic [7:0] seen[$];
    for (int i = 0; i < SLOTS; i++) begin
      oldq.push_back(model_prev[i]);
      newq.push_back(r[8*i +: 8]);
    end
    foreach (oldq[i])
      if (oldq[i] != 8'h00 && !has(newq, oldq[i]) && !has(seen, oldq[i])) begin
        exp_q.push_back({oldq[i], 1'b0});
        seen.push_back(oldq[i]);
      end
    seen.delete();
    foreach (newq[i])
      if (newq[i] != 8'h00 && !has(oldq, newq[i]) && !has(seen, newq[i])) begin
        exp_q.push_back({newq[i], 1'b1});
        seen.push_back(newq[i]);
      end
    foreach (newq[i]) model_prev[i] = newq[i];
  endfunction

  function automatic logic [7:0] pick();
    logic [7:0] keys[6];
    keys = '{8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    return keys[$urandom_range(0, 5)];
  endfunction

  initial begin
    int lat;
    reset = 1'b1;
    report_strobe = 1'b0;
    keycode_in = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_code", 32'({evt_code, evt_press}), 0);
    reset = 1'b0;

    // vector table, starting from an all-empty previous report
    tbl[0]  = '{mk(8'h00, 8'h00, 8'h00, 8'h00), 0, 9'h0, 9'h0};
    tbl[1]  = '{mk(8'h00, 8'h00, 8'h00, 8'h04), 1, ev(8'h04, 1), 9'h0};
    tbl[2]  = '{mk(8'h00, 8'h00, 8'h00, 8'h00), 1, ev(8'h04, 0), 9'h0};
    tbl[3]  = '{mk(8'h04, 8'h16, 8'h00, 8'h00), 2, ev(8'h04, 1), ev(8'h16, 1)};
    tbl[4]  = '{mk(8'h07, 8'h04, 8'h00, 8'h00), 2, ev(8'h16, 0), ev(8'h07, 1)};
    tbl[5]  = '{mk(8'h04, 8'h1A, 8'h00, 8'h00), 2, ev(8'h07, 0), ev(8'h1A, 1)};
    tbl[6]  = '{mk(8'h1A, 8'h04, 8'h00, 8'h00), 0, 9'h0, 9'h0};
    tbl[7]  = '{mk(8'h00, 8'h00, 8'h00, 8'h00), 2, ev(8'h1A, 0), ev(8'h04, 0)};
    tbl[8]  = '{mk(8'h2C, 8'h2C, 8'h00, 8'h00), 1, ev(8'h2C, 1), 9'h0};
    tbl[9]  = '{mk(8'h00, 8'h2C, 8'h00, 8'h2C), 0, 9'h0, 9'h0};
    tbl[10] = '{mk(8'h00, 8'h00, 8'h00, 8'h00), 1, ev(8'h2C, 0), 9'h0};

    rdy_mode = 1;
    for (int v = 0; v < 11; v++) begin
      if (tbl[v].n > 0) exp_q.push_back(tbl[v].ev0);
      if (tbl[v].n > 1) exp_q.push_back(tbl[v].ev1);
      send(tbl[v].rpt, lat);
      check($sformatf("tbl%0d_latency", v), 32'(lat), LAT);
      drain($sformatf("tbl%0d", v));
    end
    check("tbl_overflow", 32'(overflow), 0);

    // overflow: 12 events against an 8-entry FIFO with the consumer stalled
    reset_dut();
    rdy_mode = 0;
    send(mk(8'h04, 8'h05, 8'h06, 8'h07), lat);
    check("ovf_first_scan", 32'(overflow), 0);
    send(mk(8'h08, 8'h09, 8'h0A, 8'h0B), lat);
    check("ovf_set", 32'(overflow), 1);
    for (int k = 4; k < 8; k++) exp_q.push_back(ev(8'(k), 1));
    for (int k = 4; k < 8; k++) exp_q.push_back(ev(8'(k), 0));
    rdy_mode = 1;
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 1);

    // three strobes on consecutive cycles: only the last waiting one is scanned
    reset_dut();
    rdy_mode = 1;
    exp_q.push_back(ev(8'h04, 1));
    exp_q.push_back(ev(8'h04, 0));
    exp_q.push_back(ev(8'h06, 1));
    @(negedge clk);
    keycode_in = mk(8'h04, 8'h00, 8'h00, 8'h00); report_strobe = 1'b1;
    @(negedge clk);
    check("pend_busy", 32'(busy), 1);
    keycode_in = mk(8'h05, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    keycode_in = mk(8'h06, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    report_strobe = 1'b0;
    repeat (2 * LAT + 4) @(negedge clk);
    check("pend_idle", 32'(busy), 0);
    drain("pend");

    // reset mid-scan with events held in the FIFO
    rdy_mode = 0;
    @(negedge clk);
    keycode_in = mk(8'h07, 8'h08, 8'h00, 8'h00); report_strobe = 1'b1;
    @(negedge clk);
    report_strobe = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_prereset_valid", 32'(evt_valid), 1);
    reset_dut();
    check("mid_valid", 32'(evt_valid), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_overflow", 32'(overflow), 0);
    rdy_mode = 1;
    send(mk(8'h00, 8'h00, 8'h00, 8'h00), lat);
    check("mid_latency", 32'(lat), LAT);
    drain("mid_after");

    // randomized reports against the reference model
    reset_dut();
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] r;
      r = {pick(), pick(), pick(), pick()};
      model_scan(r);
      send(r, lat);
      check("rand_latency", 32'(lat), LAT);
      drain("rand");
    end
    check("rand_overflow", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
